// File: rtl/issue_mem_q_pkg.sv
// Shared types for the memory-op issue queue: operand, broadcast, dispatch and FU packet records.
// Also carries the default MEM_Q_DEPTH / MEM_Q_NUM_CDB sizing used by issue_mem_q.
package issue_mem_q_pkg;

  localparam int MEM_Q_DEPTH   = 8;
  localparam int MEM_Q_NUM_CDB = 2;
  localparam int XLEN          = 32;
  localparam int TAG_W         = 6;

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [1:0] {
    to_alu = 2'd0,
    to_mem = 2'd1,
    to_br  = 2'd2,
    to_mul = 2'd3
  } funct_unit_e;

  typedef enum logic [1:0] {
    NOT_LS   = 2'd0,
    IS_LOAD  = 2'd1,
    IS_STORE = 2'd2
  } ls_e;

  typedef enum logic [1:0] {
    NOT_BJ = 2'd0,
    IS_BR  = 2'd1,
    IS_JMP = 2'd2
  } bj_e;

  typedef struct packed {
    logic [31:0] insn;
  } rvfi_t;

  typedef struct packed {
    logic            valid;
    tag_t            tag;
    logic [XLEN-1:0] data;
  } rs_t;

  typedef struct packed {
    logic            valid;
    tag_t            tag;
    logic [XLEN-1:0] data;
  } cdb_t;

  typedef struct packed {
    logic            valid;
    logic            busy;
    bj_e             bj;
    tag_t            tag;
    logic [XLEN-1:0] data;
  } rob_cell_t;

  typedef struct packed {
    funct_unit_e     funct_unit;
    ls_e             ls;
    logic [2:0]      mem_op;
    rs_t             rs1;
    rs_t             rs2;
    logic [XLEN-1:0] imm;
    tag_t            rob_tag;
    logic [XLEN-1:0] pc;
    rvfi_t           rvfi;
  } decode_to_issue_t;

  typedef struct packed {
    logic            valid;
    logic [3:0]      alu_op;
    logic [2:0]      mem_op;
    logic [XLEN-1:0] rs1_v;
    logic [XLEN-1:0] rs2_v;
    logic [XLEN-1:0] offset;
    tag_t            rob_tag;
    logic [XLEN-1:0] pc;
    ls_e             ls;
    rvfi_t           rvfi;
  } fu_pkt_t;

  typedef struct packed {
    logic            valid;
    ls_e             ls;
    logic [2:0]      mem_op;
    rs_t             rs1;
    rs_t             rs2;
    logic [XLEN-1:0] imm;
    tag_t            rob_tag;
    logic [XLEN-1:0] pc;
    rvfi_t           rvfi;
  } mem_entry_t;

  // Stores need the data operand too; loads only need the address base.
  function automatic logic entry_ready(input mem_entry_t e);
    return e.valid && e.rs1.valid && ((e.ls == IS_STORE) ? e.rs2.valid : 1'b1);
  endfunction

endpackage

// File: rtl/issue_mem_wakeup.sv
// Single-operand wakeup: snoops all CDB ports and the commit forward for a tag match.
// Lowest CDB index wins, and any CDB hit wins over the commit forward.
module issue_mem_wakeup
  import issue_mem_q_pkg::*;
#(
  parameter int NUM_CDB = MEM_Q_NUM_CDB
) (
  input  rs_t       rs_i,
  input  cdb_t      cdb_i [NUM_CDB],
  input  rob_cell_t fwd_i,
  output rs_t       rs_o
);

  logic hit;

  always_comb begin
    rs_o = rs_i;
    hit  = 1'b0;
    if (!rs_i.valid) begin
      for (int k = 0; k < NUM_CDB; k++) begin
        if (!hit && cdb_i[k].valid && (cdb_i[k].tag == rs_i.tag)) begin
          rs_o.valid = 1'b1;
          rs_o.data  = cdb_i[k].data;
          hit        = 1'b1;
        end
      end
      // Branch entries in the ROB carry no register result worth forwarding.
      if (!hit && fwd_i.valid && !fwd_i.busy && (fwd_i.bj != IS_BR) &&
          (fwd_i.tag == rs_i.tag)) begin
        rs_o.valid = 1'b1;
        rs_o.data  = fwd_i.data;
      end
    end
  end

endmodule

// File: rtl/issue_mem_q.sv
// Age-ordered circular issue queue feeding the MEM FU; oldest ready op issues each cycle.
// Define ISSUE_MEM_LD_BYPASS_EN to let a ready load pass older unready loads (never a store).
module issue_mem_q
  import issue_mem_q_pkg::*;
#(
  parameter int DEPTH   = MEM_Q_DEPTH,
  parameter int NUM_CDB = MEM_Q_NUM_CDB
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  cdb_t                   cdb [NUM_CDB],
  input  rob_cell_t              forward_from_commit,
  input  logic                   inst_valid,
  input  decode_to_issue_t       inst_pkt,
  output logic                   mem_inst_ready,
  input  logic                   backpressure,
  output fu_pkt_t                mem_pkt,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

`ifdef ISSUE_MEM_LD_BYPASS_EN
  localparam bit LD_BYPASS = 1'b1;
`else
  localparam bit LD_BYPASS = 1'b0;
`endif

  typedef logic [PW-1:0] ptr_t;
  typedef logic [IW-1:0] idx_t;

  mem_entry_t       entries_q [DEPTH];
  mem_entry_t       entries_d [DEPTH];
  ptr_t             head_q, head_d, tail_q, tail_d;
  rs_t              wk_rs1 [DEPTH];
  rs_t              wk_rs2 [DEPTH];
  rs_t              enq_rs1, enq_rs2;
  logic [DEPTH-1:0] ready;
  logic             empty, full, want_mem, enq, deq;
  logic             cand_valid, store_seen;
  idx_t             hidx, tidx, cand_idx, scan_idx;

  assign hidx           = head_q[IW-1:0];
  assign tidx           = tail_q[IW-1:0];
  assign occupancy      = tail_q - head_q;
  assign empty          = (head_q == tail_q);
  assign full           = (hidx == tidx) && (head_q[IW] != tail_q[IW]);
  assign want_mem       = (inst_pkt.funct_unit == to_mem);
  assign mem_inst_ready = want_mem && !full;
  assign enq            = inst_valid && mem_inst_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    issue_mem_wakeup #(.NUM_CDB(NUM_CDB)) u_wk_rs1 (
      .rs_i  (entries_q[i].rs1),
      .cdb_i (cdb),
      .fwd_i (forward_from_commit),
      .rs_o  (wk_rs1[i])
    );
    issue_mem_wakeup #(.NUM_CDB(NUM_CDB)) u_wk_rs2 (
      .rs_i  (entries_q[i].rs2),
      .cdb_i (cdb),
      .fwd_i (forward_from_commit),
      .rs_o  (wk_rs2[i])
    );
    assign ready[i] = entry_ready(entries_q[i]);
  end

  // Dispatch-cycle snoop so an operand broadcast alongside dispatch is not lost.
  issue_mem_wakeup #(.NUM_CDB(NUM_CDB)) u_wk_enq_rs1 (
    .rs_i  (inst_pkt.rs1),
    .cdb_i (cdb),
    .fwd_i (forward_from_commit),
    .rs_o  (enq_rs1)
  );
  issue_mem_wakeup #(.NUM_CDB(NUM_CDB)) u_wk_enq_rs2 (
    .rs_i  (inst_pkt.rs2),
    .cdb_i (cdb),
    .fwd_i (forward_from_commit),
    .rs_o  (enq_rs2)
  );

  // Candidate select walks from head so the first hit is the oldest eligible op.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = hidx;
    store_seen = 1'b0;
    scan_idx   = hidx;
    if (!empty && ready[hidx]) begin
      cand_valid = 1'b1;
    end else if (LD_BYPASS) begin
      for (int j = 0; j < DEPTH; j++) begin
        scan_idx = hidx + idx_t'(j);
        if (ptr_t'(j) < occupancy) begin
          if (!cand_valid && !store_seen && entries_q[scan_idx].valid &&
              (entries_q[scan_idx].ls == IS_LOAD) && ready[scan_idx]) begin
            cand_valid = 1'b1;
            cand_idx   = scan_idx;
          end
          if (entries_q[scan_idx].valid && (entries_q[scan_idx].ls == IS_STORE)) begin
            store_seen = 1'b1;
          end
        end
      end
    end
  end

  assign deq = cand_valid && !backpressure;

  always_comb begin
    mem_pkt = '0;
    if (deq) begin
      mem_pkt.valid   = 1'b1;
      mem_pkt.mem_op  = entries_q[cand_idx].mem_op;
      mem_pkt.rs1_v   = entries_q[cand_idx].rs1.data;
      mem_pkt.rs2_v   = (entries_q[cand_idx].ls == IS_STORE) ? entries_q[cand_idx].rs2.data : '0;
      mem_pkt.offset  = entries_q[cand_idx].imm;
      mem_pkt.rob_tag = entries_q[cand_idx].rob_tag;
      mem_pkt.pc      = entries_q[cand_idx].pc;
      mem_pkt.ls      = entries_q[cand_idx].ls;
      mem_pkt.rvfi    = entries_q[cand_idx].rvfi;
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
      head_d = '0;
      tail_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries_q[i].valid) begin
          entries_d[i].rs1 = wk_rs1[i];
          entries_d[i].rs2 = wk_rs2[i];
        end
      end
      if (deq) entries_d[cand_idx].valid = 1'b0;
      if (enq) begin
        entries_d[tidx] = '{valid:   1'b1,
                            ls:      inst_pkt.ls,
                            mem_op:  inst_pkt.mem_op,
                            rs1:     enq_rs1,
                            rs2:     enq_rs2,
                            imm:     inst_pkt.imm,
                            rob_tag: inst_pkt.rob_tag,
                            pc:      inst_pkt.pc,
                            rvfi:    inst_pkt.rvfi};
        tail_d = tail_q + 1'b1;
      end
      // Holes left by bypassed loads are retired one per cycle as head reaches them.
      if (!empty && (!entries_q[hidx].valid || (deq && (cand_idx == hidx)))) begin
        head_d = head_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_issue_mem_q.sv
// Directed bench for issue_mem_q: table of per-cycle vectors plus hand sequences for wakeup,
// backpressure, bypass, flush, pointer wrap and async reset.
module tb_issue_mem_q;
  import issue_mem_q_pkg::*;

  localparam int DEPTH   = MEM_Q_DEPTH;
  localparam int NUM_CDB = MEM_Q_NUM_CDB;
  localparam int OW      = $clog2(DEPTH) + 1;

`ifdef ISSUE_MEM_LD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush;
  cdb_t             cdb [NUM_CDB];
  rob_cell_t        fwd;
  logic             inst_valid;
  decode_to_issue_t inst_pkt;
  logic             mem_inst_ready;
  logic             backpressure;
  fu_pkt_t          mem_pkt;
  logic [OW-1:0]    occupancy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  typedef struct packed {
    logic          iv;
    logic          is_mem;
    logic [7:0]    tag;
    logic          bp;
    logic          exp_rdy;
    logic          exp_mv;
    logic [7:0]    exp_tag;
    logic [OW-1:0] exp_occ;
  } vec_t;

  vec_t vecs[$];

  issue_mem_q dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush               (flush),
    .cdb                 (cdb),
    .forward_from_commit (fwd),
    .inst_valid          (inst_valid),
    .inst_pkt            (inst_pkt),
    .mem_inst_ready      (mem_inst_ready),
    .backpressure        (backpressure),
    .mem_pkt             (mem_pkt),
    .occupancy           (occupancy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush        = 1'b0;
    inst_valid   = 1'b0;
    backpressure = 1'b0;
    inst_pkt     = '0;
    inst_pkt.funct_unit = to_mem;
    for (int k = 0; k < NUM_CDB; k++) cdb[k] = '0;
    fwd = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic decode_to_issue_t mk_load(input logic [7:0] rob, input logic r1v,
                                               input logic [7:0] r1tag);
    decode_to_issue_t p;
    p            = '0;
    p.funct_unit = to_mem;
    p.ls         = IS_LOAD;
    p.mem_op     = 3'd2;
    p.rs1.valid  = r1v;
    p.rs1.tag    = r1tag[TAG_W-1:0];
    p.rs1.data   = 32'h1000 + 32'(rob);
    p.imm        = 32'h40 + 32'(rob);
    p.rob_tag    = rob[TAG_W-1:0];
    p.pc         = 32'h8000_0000 + 32'(rob) * 4;
    p.rvfi.insn  = 32'h0000_2003 + 32'(rob);
    return p;
  endfunction

  function automatic decode_to_issue_t mk_store(input logic [7:0] rob, input logic r1v,
                                                input logic [7:0] r1tag, input logic r2v,
                                                input logic [7:0] r2tag);
    decode_to_issue_t p;
    p           = mk_load(rob, r1v, r1tag);
    p.ls        = IS_STORE;
    p.mem_op    = 3'd5;
    p.rs2.valid = r2v;
    p.rs2.tag   = r2tag[TAG_W-1:0];
    p.rs2.data  = 32'h55;
    return p;
  endfunction

  task automatic add_vec(input logic iv, input logic is_mem, input int tag, input logic bp,
                         input logic rdy, input logic mv, input int etag, input int occ);
    vec_t v;
    v.iv      = iv;
    v.is_mem  = is_mem;
    v.tag     = 8'(tag);
    v.bp      = bp;
    v.exp_rdy = rdy;
    v.exp_mv  = mv;
    v.exp_tag = 8'(etag);
    v.exp_occ = OW'(occ);
    vecs.push_back(v);
  endtask

  task automatic enq_only(input decode_to_issue_t p, input logic bp);
    next_cycle();
    inst_valid   = 1'b1;
    inst_pkt     = p;
    backpressure = bp;
    sample();
  endtask

  // ---------------- test ----------------
  initial begin
    int issued;
    int sent;
    int cyc;
    logic [7:0] exp_tag;

    // Streaming 8 loads: each issues the cycle after it is enqueued.
    add_vec(1, 1, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k < 8; k++) add_vec(1, 1, k, 0, 1, 1, k - 1, 1);
    add_vec(0, 1, 0, 0, 1, 1, 7, 1);
    add_vec(0, 1, 0, 0, 1, 0, 0, 0);
    add_vec(1, 0, 40, 0, 0, 0, 0, 0);
    // Fill under backpressure; the 9th stays blocked while full, even with a same-cycle issue.
    for (int k = 0; k < 8; k++) add_vec(1, 1, 16 + k, 1, 1, 0, 0, k);
    add_vec(1, 1, 24, 1, 0, 0, 0, 8);
    add_vec(1, 1, 24, 0, 0, 1, 16, 8);
    add_vec(1, 1, 24, 0, 1, 1, 17, 7);
    for (int k = 0; k < 7; k++) add_vec(0, 1, 0, 0, 1, 1, 18 + k, 7 - k);
    add_vec(0, 1, 0, 0, 1, 0, 0, 0);

    idle_inputs();
    repeat (2) @(posedge clk);
    sample();
    check("reset_mem_pkt_zero", 64'(mem_pkt == '0), 1);
    check("reset_ready", 64'(mem_inst_ready), 1);
    check("reset_occ", 64'(occupancy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      next_cycle();
      inst_pkt            = mk_load(vecs[i].tag, 1'b1, 8'd0);
      inst_pkt.funct_unit = vecs[i].is_mem ? to_mem : to_alu;
      inst_valid          = vecs[i].iv;
      backpressure        = vecs[i].bp;
      sample();
      check($sformatf("vec%0d_ready", i), 64'(mem_inst_ready), 64'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_mv", i), 64'(mem_pkt.valid), 64'(vecs[i].exp_mv));
      check($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(vecs[i].exp_occ));
      if (vecs[i].exp_mv) begin
        check($sformatf("vec%0d_tag", i), 64'(mem_pkt.rob_tag), 64'(vecs[i].exp_tag[TAG_W-1:0]));
        check($sformatf("vec%0d_rs1", i), 64'(mem_pkt.rs1_v), 64'(32'h1000 + 32'(vecs[i].exp_tag)));
        check($sformatf("vec%0d_rs2", i), 64'(mem_pkt.rs2_v), 0);
      end
    end

    // Store waiting on rs2 tag 5: branch-flagged commit forward must not wake it.
    enq_only(mk_store(8'd30, 1'b1, 8'd0, 1'b0, 8'd5), 1'b0);
    next_cycle();
    fwd.valid = 1'b1; fwd.busy = 1'b0; fwd.bj = IS_BR; fwd.tag = 6'd5; fwd.data = 32'hBAD;
    sample();
    check("st_wait_mv", 64'(mem_pkt.valid), 0);
    next_cycle();
    sample();
    check("st_br_fwd_no_wake", 64'(mem_pkt.valid), 0);
    next_cycle();
    cdb[1].valid = 1'b1; cdb[1].tag = 6'd5; cdb[1].data = 32'hCAFE;
    sample();
    check("st_cdb_cycle_mv", 64'(mem_pkt.valid), 0);
    next_cycle();
    sample();
    check("st_issue_mv", 64'(mem_pkt.valid), 1);
    check("st_issue_rs2", 64'(mem_pkt.rs2_v), 64'h0000_CAFE);
    check("st_issue_tag", 64'(mem_pkt.rob_tag), 30);
    check("st_issue_ls", 64'(mem_pkt.ls), 64'(IS_STORE));
    check("st_issue_off", 64'(mem_pkt.offset), 64'(32'h40 + 32'd30));
    next_cycle();
    sample();
    check("st_after_occ", 64'(occupancy), 0);

    // Dispatch-cycle CDB snoop.
    next_cycle();
    inst_valid   = 1'b1;
    inst_pkt     = mk_load(8'd31, 1'b0, 8'd3);
    cdb[0].valid = 1'b1; cdb[0].tag = 6'd3; cdb[0].data = 32'h1234;
    sample();
    check("snoop_enq_cycle_mv", 64'(mem_pkt.valid), 0);
    next_cycle();
    sample();
    check("snoop_issue_mv", 64'(mem_pkt.valid), 1);
    check("snoop_issue_rs1", 64'(mem_pkt.rs1_v), 64'h1234);
    check("snoop_issue_tag", 64'(mem_pkt.rob_tag), 31);

    // Backpressure holds a ready head.
    enq_only(mk_load(8'd9, 1'b1, 8'd0), 1'b0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      backpressure = 1'b1;
      sample();
      check($sformatf("bp%0d_pkt_zero", k), 64'(mem_pkt == '0), 1);
      check($sformatf("bp%0d_occ", k), 64'(occupancy), 1);
    end
    next_cycle();
    sample();
    check("bp_release_mv", 64'(mem_pkt.valid), 1);
    check("bp_release_tag", 64'(mem_pkt.rob_tag), 9);
    next_cycle();
    sample();
    check("bp_after_occ", 64'(occupancy), 0);

    // Load bypass: L0 unready at head, L1 ready behind it.
    enq_only(mk_load(8'd20, 1'b0, 8'd10), 1'b0);
    enq_only(mk_load(8'd21, 1'b1, 8'd0), 1'b0);
    check("byp_l0_wait_mv", 64'(mem_pkt.valid), 0);
    next_cycle();
    cdb[0].valid = 1'b1; cdb[0].tag = 6'd10; cdb[0].data = 32'h77;
    sample();
    check("byp_l1_mv", 64'(mem_pkt.valid), BYPASS ? 1 : 0);
    check("byp_l1_tag", mem_pkt.valid ? 64'(mem_pkt.rob_tag) : 0, BYPASS ? 21 : 0);
    next_cycle();
    sample();
    check("byp_l0_mv", 64'(mem_pkt.valid), 1);
    check("byp_l0_tag", 64'(mem_pkt.rob_tag), 20);
    check("byp_l0_rs1", 64'(mem_pkt.rs1_v), 64'h77);
    check("byp_l0_occ", 64'(occupancy), 2);
    next_cycle();
    sample();
    check("byp_tail_mv", 64'(mem_pkt.valid), BYPASS ? 0 : 1);
    check("byp_tail_tag", mem_pkt.valid ? 64'(mem_pkt.rob_tag) : 0, BYPASS ? 0 : 21);
    check("byp_tail_occ", 64'(occupancy), 1);
    next_cycle();
    sample();
    check("byp_drain_occ", 64'(occupancy), 0);

    // A ready load never passes an older unready store.
    enq_only(mk_store(8'd22, 1'b0, 8'd11, 1'b1, 8'd0), 1'b0);
    enq_only(mk_load(8'd23, 1'b1, 8'd0), 1'b0);
    check("nps_s0_wait_mv", 64'(mem_pkt.valid), 0);
    next_cycle();
    cdb[1].valid = 1'b1; cdb[1].tag = 6'd11; cdb[1].data = 32'h88;
    sample();
    check("nps_l1_blocked_mv", 64'(mem_pkt.valid), 0);
    next_cycle();
    sample();
    check("nps_s0_tag", 64'(mem_pkt.rob_tag), 22);
    check("nps_s0_rs2", 64'(mem_pkt.rs2_v), 64'h55);
    next_cycle();
    sample();
    check("nps_l1_tag", 64'(mem_pkt.rob_tag), 23);
    check("nps_l1_mv", 64'(mem_pkt.valid), 1);

    // Flush with 5 entries and a ready head; the same-cycle enqueue is dropped.
    for (int k = 0; k < 5; k++) enq_only(mk_load(8'(50 + k), 1'b1, 8'd0), 1'b1);
    check("flush_pre_occ", 64'(occupancy), 4);
    next_cycle();
    flush      = 1'b1;
    inst_valid = 1'b1;
    inst_pkt   = mk_load(8'd60, 1'b1, 8'd0);
    sample();
    next_cycle();
    sample();
    check("flush_occ", 64'(occupancy), 0);
    check("flush_pkt_zero", 64'(mem_pkt == '0), 1);
    check("flush_ready", 64'(mem_inst_ready), 1);
    next_cycle();
    sample();
    check("flush_stays_empty", 64'(occupancy), 0);

    // Pointer wrap: 3*DEPTH ops with periodic backpressure, checked against exp_q.
    issued = 0;
    sent   = 0;
    cyc    = 0;
    while ((issued < 3 * DEPTH) && (cyc < 400)) begin
      next_cycle();
      if (sent < 3 * DEPTH) begin
        inst_valid = 1'b1;
        inst_pkt   = mk_load(8'(sent), 1'b1, 8'd0);
      end
      backpressure = ((cyc % 4) == 3);
      sample();
      if (mem_pkt.valid) begin
        if (exp_q.size() == 0) begin
          check("wrap_unexpected_issue", 64'(mem_pkt.rob_tag), 64'hFFFF);
        end else begin
          exp_tag = exp_q.pop_front();
          check($sformatf("wrap_tag%0d", issued), 64'(mem_pkt.rob_tag), 64'(exp_tag[TAG_W-1:0]));
        end
        issued++;
      end
      if (inst_valid && mem_inst_ready) begin
        exp_q.push_back(8'(sent));
        sent++;
      end
      cyc++;
    end
    check("wrap_all_issued", 64'(issued), 3 * DEPTH);

    // Async reset mid-operation clears immediately.
    enq_only(mk_load(8'd40, 1'b1, 8'd0), 1'b1);
    enq_only(mk_load(8'd41, 1'b1, 8'd0), 1'b1);
    next_cycle();
    sample();
    check("arst_pre_mv", 64'(mem_pkt.valid), 1);
    rst_n = 1'b0;
    #1;
    check("arst_pkt_zero", 64'(mem_pkt == '0), 1);
    check("arst_occ", 64'(occupancy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sample();
    check("arst_after_occ", 64'(occupancy), 0);
    check("arst_after_mv", 64'(mem_pkt.valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
